// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and helpers for the round-robin register arbiter
package arbitro_pkg;

  localparam int R_MAX = 8;

  typedef enum logic {IDLE, LOAD} estado_t;

  // Sized for the widest legal requester count; callers cast down to R bits.
  function automatic logic [R_MAX-1:0] onehot(input logic [2:0] idx);
    logic [R_MAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/registro_param.sv
// rtl/registro_param.sv - N-bit storage register with synchronous reset and load enable
module registro_param #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting after ptr
module rr_picker #(
  parameter int R = 4,
  localparam int W = $clog2(R)
) (
  input  logic [R-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_req_o
);

  int c;

  // Offsets run 1..R so the previous owner is scanned last; modulo keeps c below R.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    c         = 0;
    for (int k = 1; k <= R; k++) begin
      c = (int'(ptr_i) + k) % R;
      if (!any_req_o && req_i[W'(c)]) begin
        any_req_o = 1'b1;
        winner_o  = W'(c);
      end
    end
  end

endmodule

// File: rtl/arbitro_registro.sv
// rtl/arbitro_registro.sv - round-robin arbiter granting R requesters write access to one shared register
module arbitro_registro
  import arbitro_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4,
  localparam int W = $clog2(R)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [R-1:0]   req_i,
  input  logic [R*N-1:0] data_i,
  output logic [R-1:0]   gnt_o,
  output logic           busy_o,
  output logic [N-1:0]   q_o,
  output logic [W-1:0]   owner_o,
  output logic           valid_o
);

  estado_t      state_q, state_d;
  logic [W-1:0] sel_q, sel_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] owner_q, owner_d;
  logic         valid_q, valid_d;

  logic [W-1:0] winner;
  logic         any_req;
  logic [N-1:0] d_sel;
  logic         load_en;

  rr_picker #(.R(R)) u_picker (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    d_sel = '0;
    for (int i = 0; i < R; i++) begin
      if (sel_q == W'(i)) begin
        d_sel = data_i[i*N +: N];
      end
    end
  end

  assign load_en = (state_q == LOAD);

  registro_param #(.N(N)) u_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (load_en),
    .d_i   (d_sel),
    .q_o   (q_o)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Once granted the load always completes, even if req drops meanwhile.
        owner_d = sel_q;
        ptr_d   = sel_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= W'(R - 1);
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = load_en;
  assign gnt_o   = load_en ? R'(onehot(3'(sel_q))) : '0;
  assign owner_o = owner_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_arbitro_registro.sv
// tb/tb_arbitro_registro.sv - table-driven scoreboard bench for arbitro_registro
module tb_arbitro_registro;

  localparam int N = 8;
  localparam int R = 4;
  localparam int W = 2;
  localparam int NV = 32;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*N-1:0] data;
  logic [R-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   q;
  logic [W-1:0]   owner;
  logic           valid;

  arbitro_registro #(.N(N), .R(R)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .data_i  (data),
    .gnt_o   (gnt),
    .busy_o  (busy),
    .q_o     (q),
    .owner_o (owner),
    .valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0]   gnt;
    logic           busy;
    logic [N-1:0]   q;
    logic [W-1:0]   owner;
    logic           valid;
  } exp_t;

  typedef struct {
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] data;
    exp_t           exp;
  } vec_t;

  vec_t tbl [NV];
  exp_t sb [$];
  int   n_checks;
  int   n_fail;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got gnt=%0h", tag, gnt);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".gnt"},   32'(gnt),   32'(e.gnt));
    cmp({tag, ".busy"},  32'(busy),  32'(e.busy));
    cmp({tag, ".q"},     32'(q),     32'(e.q));
    cmp({tag, ".owner"}, 32'(owner), 32'(e.owner));
    cmp({tag, ".valid"}, 32'(valid), 32'(e.valid));
  endtask

  task automatic drive(input logic r, input logic [R-1:0] rq, input logic [R*N-1:0] d,
                       input exp_t e, input string tag);
    rst  = r;
    req  = rq;
    data = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  function automatic exp_t ex(input logic [R-1:0] g, input logic b, input logic [N-1:0] qq,
                              input logic [W-1:0] o, input logic v);
    exp_t e;
    e.gnt = g; e.busy = b; e.q = qq; e.owner = o; e.valid = v;
    return e;
  endfunction

  function automatic vec_t vv(input logic r, input logic [R-1:0] rq, input logic [R*N-1:0] d,
                              input exp_t e);
    vec_t x;
    x.rst = r; x.req = rq; x.data = d; x.exp = e;
    return x;
  endfunction

  initial begin
    logic [R*N-1:0] dw;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    @(negedge clk);

    // reset, then single request from requester 2
    tbl[0]  = vv(1, 4'b0000, 32'h0000_0000, ex(4'b0000, 0, 8'h00, 0, 0));
    tbl[1]  = vv(1, 4'b0000, 32'h0000_0000, ex(4'b0000, 0, 8'h00, 0, 0));
    tbl[2]  = vv(0, 4'b0100, 32'h00A5_0000, ex(4'b0100, 1, 8'h00, 0, 0));
    tbl[3]  = vv(0, 4'b0100, 32'h00A5_0000, ex(4'b0000, 0, 8'hA5, 2, 1));
    tbl[4]  = vv(0, 4'b0000, 32'h0000_0000, ex(4'b0000, 0, 8'hA5, 2, 1));
    // all requesting after a fresh reset
    tbl[5]  = vv(1, 4'b0000, 32'h4433_2211, ex(4'b0000, 0, 8'h00, 0, 0));
    tbl[6]  = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0001, 1, 8'h00, 0, 0));
    tbl[7]  = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0000, 0, 8'h11, 0, 1));
    tbl[8]  = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0010, 1, 8'h11, 0, 1));
    tbl[9]  = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0000, 0, 8'h22, 1, 1));
    tbl[10] = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0100, 1, 8'h22, 1, 1));
    tbl[11] = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0000, 0, 8'h33, 2, 1));
    tbl[12] = vv(0, 4'b1111, 32'h4433_2211, ex(4'b1000, 1, 8'h33, 2, 1));
    tbl[13] = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0000, 0, 8'h44, 3, 1));
    tbl[14] = vv(0, 4'b1111, 32'h4433_2211, ex(4'b0001, 1, 8'h44, 3, 1));
    tbl[15] = vv(0, 4'b0000, 32'h4433_2211, ex(4'b0000, 0, 8'h11, 0, 1));
    // move ptr to 3, then fairness across the wrap
    tbl[16] = vv(0, 4'b1000, 32'h4433_2211, ex(4'b1000, 1, 8'h11, 0, 1));
    tbl[17] = vv(0, 4'b1000, 32'h4433_2211, ex(4'b0000, 0, 8'h44, 3, 1));
    tbl[18] = vv(0, 4'b1001, 32'h4433_2211, ex(4'b0001, 1, 8'h44, 3, 1));
    tbl[19] = vv(0, 4'b1001, 32'h4433_2211, ex(4'b0000, 0, 8'h11, 0, 1));
    tbl[20] = vv(0, 4'b1001, 32'h4433_2211, ex(4'b1000, 1, 8'h11, 0, 1));
    tbl[21] = vv(0, 4'b0000, 32'h4433_2211, ex(4'b0000, 0, 8'h44, 3, 1));
    // requester 1 drops req in its grant cycle
    tbl[22] = vv(0, 4'b0010, 32'h4433_5C11, ex(4'b0010, 1, 8'h44, 3, 1));
    tbl[23] = vv(0, 4'b0000, 32'h4433_5C11, ex(4'b0000, 0, 8'h5C, 1, 1));
    tbl[24] = vv(0, 4'b0000, 32'h4433_5C11, ex(4'b0000, 0, 8'h5C, 1, 1));
    // reset during LOAD, with a new request rising under reset
    tbl[25] = vv(0, 4'b0010, 32'h4433_5C11, ex(4'b0010, 1, 8'h5C, 1, 1));
    tbl[26] = vv(1, 4'b0011, 32'h4433_5C11, ex(4'b0000, 0, 8'h00, 0, 0));
    tbl[27] = vv(0, 4'b0011, 32'h4433_5C11, ex(4'b0001, 1, 8'h00, 0, 0));
    tbl[28] = vv(0, 4'b0011, 32'h4433_5C11, ex(4'b0000, 0, 8'h11, 0, 1));
    tbl[29] = vv(0, 4'b0000, 32'h4433_5C11, ex(4'b0000, 0, 8'h11, 0, 1));
    // load 3C ahead of the idle-hold sequence
    tbl[30] = vv(0, 4'b0001, 32'h4433_5C3C, ex(4'b0001, 1, 8'h11, 0, 1));
    tbl[31] = vv(0, 4'b0001, 32'h4433_5C3C, ex(4'b0000, 0, 8'h3C, 0, 1));

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].exp, $sformatf("v%0d", i));
    end

    // idle hold: data churns with no request, register must not move
    for (int i = 0; i < 10; i++) begin
      dw = {$urandom, $urandom};
      drive(0, 4'b0000, dw, ex(4'b0000, 0, 8'h3C, 0, 1), $sformatf("idle%0d", i));
    end

    cmp("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/arbitro_registro.md
Name: arbitro_registro

Overview:
- Round-robin write arbiter sharing one N-bit storage register among R requesters.
- Each requester raises req with its data word. The arbiter grants one requester at a time, loads that word into the shared register, and reports which requester wrote last.
- Sits between multiple FSM/datapath producers and a single shared registro_param instance. That instance is the only storage for the data word.

Parameters:
- N, 8, data width of each requester word and of the stored register.
- R, 4, number of requesters; legal range 2..8.
- W, $clog2(R), width of the owner index; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  R  per-requester write request; bit i belongs to requester i.
- data  input  R*N  flattened words; requester i occupies data[i*N +: N].
- gnt  output  R  one-hot grant; high for exactly the LOAD cycle.
- busy  output  1  high while state is LOAD.
- q  output  N  contents of the shared register.
- owner  output  W  index of the requester that performed the last load.
- valid  output  1  high once at least one load has completed since reset.

Behaviour:
- Reset: sampled only on the rising edge of clk when rst=1.
  - Outputs: gnt=0, busy=0, q=0, owner=0, valid=0.
  - Internal: state=IDLE, round-robin pointer ptr=R-1, so requester 0 has top priority after reset.
- FSM states: IDLE and LOAD.
- IDLE:
  - If req==0, stay in IDLE; gnt=0.
  - If req!=0, pick winner w = first set bit of req, scanning ptr+1, ptr+2, … modulo R.
  - Then register sel<=w and gnt<=onehot(w), and go to LOAD.
- LOAD:
  - gnt=onehot(sel), busy=1.
  - Register enable is high with d=data[sel]; data is sampled during this cycle, not during IDLE.
  - At the closing edge: q<=data[sel], owner<=sel, ptr<=sel, valid<=1, gnt<=0, and go to IDLE.
- Latency: req first seen high in IDLE at cycle t gives gnt high in cycle t+1. q shows the new value in cycle t+2.
- Throughput: one load every 2 cycles at most; the IDLE cycle always separates grants.
- Requester contract: hold req and data stable until gnt is seen. Drop req in the cycle after gnt, or keep it to request again.
- Fairness:
  - A requester that keeps req high after its grant is placed last in the next scan, because ptr now equals its index.
  - With all R requesting continuously, grant order is 0,1,…,R-1,0,…
- Mid-request drop: if req[sel] drops during LOAD, the load still completes. The grant is committed once issued.
- Simultaneous requests: only the round-robin winner is granted. The others stay pending with no loss, since req is level-sensitive.
- Register storage: the enable is asserted only in LOAD. In IDLE, q holds its value regardless of data activity.
- Reset during LOAD: the reset takes priority. The pending load is discarded and q=0.
- Reset in the same cycle as a req rise: the reset wins and no grant is issued.
- R not a power of two: ptr wraps from R-1 to 0. Winner indices ≥R are never produced.

Decomposition:
- Package arbitro_pkg holds:
  - typedef enum logic {IDLE, LOAD} estado_t;
  - a function onehot(idx) returning an R-bit one-hot vector.
- Sub-module rr_picker (combinational) takes req and ptr and produces winner index plus an any_req flag.
- The shared register is an instance of registro_param #(N), with en=(state==LOAD), rst=rst and d=data[sel].
- The FSM, sel, ptr, owner and valid registers live in arbitro_registro.

Test Plan:
- Reset then single request: rst for 2 cycles; req=4'b0100 with data[2]=8'hA5 → gnt=4'b0100 one cycle later, q=8'hA5 and owner=2 the cycle after, valid=1.
- All requesting: req=4'b1111 with distinct words 8'h11/22/33/44 held 8 cycles → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000; q follows 11,22,33,44.
- Fairness after wrap: ptr=3 with req=4'b1001 → requester 0 is granted first, then requester 3; not requester 3 twice in a row.
- Drop during LOAD: req[1] falls in the gnt cycle with data[1]=8'h5C → q=8'h5C still loads, owner=1, and no second grant to requester 1.
- Reset mid-LOAD: rst=1 in the cycle gnt=4'b0010 → next cycle q=8'h00, gnt=0, valid=0, state IDLE; with req=4'b0011 still high, requester 0 is granted next.
- Idle hold: load 8'h3C, then req=0 while data toggles randomly for 10 cycles → q stays 8'h3C, gnt=0 and busy=0 throughout.
